// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: operation encoding and count sizing.
package stack_pkg;

  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_BYPASS  = 3'd4;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module stack_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr_top,
  output logic [DATA_WIDTH-1:0] rdata_top,
  input  logic [ADDR_W-1:0]     raddr_pop,
  output logic [DATA_WIDTH-1:0] rdata_pop
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage write; out-of-range addresses are dropped, contents are never reset
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(DEPTH))) begin
      mem_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata_top = (raddr_top < ADDR_W'(DEPTH)) ? mem_q[raddr_top[IDX_W-1:0]]
                                                  : {DATA_WIDTH{1'b0}};
  assign rdata_pop = (raddr_pop < ADDR_W'(DEPTH)) ? mem_q[raddr_pop[IDX_W-1:0]]
                                                  : {DATA_WIDTH{1'b0}};

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with peek, replace-top, bypass and sticky error flags.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  error_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [2:0]            op_s;
  logic                  we_s;
  logic [CNT_W-1:0]      waddr_s;
  logic [CNT_W-1:0]      top_idx_s;
  logic [DATA_WIDTH-1:0] rd_top_s;
  logic [DATA_WIDTH-1:0] rd_pop_s;

  assign top_idx_s = count_q - CNT_W'(1);

  stack_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (CNT_W)
  ) u_regfile (
    .clk        (clk),
    .we         (we_s && !reset),
    .waddr      (waddr_s),
    .wdata      (data_in),
    .raddr_top  (top_idx_s),
    .rdata_top  (rd_top_s),
    .raddr_pop  (top_idx_s),
    .rdata_pop  (rd_pop_s)
  );

  // Operation decode; push+pop splits on emptiness into replace-top or bypass
  always_comb begin
    op_s = OP_IDLE;
    case ({push, pop})
      2'b10:   op_s = OP_PUSH;
      2'b01:   op_s = OP_POP;
      2'b11:   op_s = empty_q ? OP_BYPASS : OP_REPLACE;
      default: op_s = OP_IDLE;
    endcase
  end

  // Next-state: rejected ops only raise an error flag, and a new error beats error_clr
  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q  && !error_clr;
    underflow_d  = underflow_q && !error_clr;
    we_s         = 1'b0;
    waddr_s      = count_q;
    case (op_s)
      OP_PUSH: begin
        if (full_q) begin
          overflow_d = 1'b1;
        end else begin
          we_s    = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty_q) begin
          underflow_d = 1'b1;
        end else begin
          data_out_d   = rd_pop_s;
          data_valid_d = 1'b1;
          count_d      = count_q - CNT_W'(1);
        end
      end
      OP_REPLACE: begin
        data_out_d   = rd_pop_s;
        data_valid_d = 1'b1;
        we_s         = 1'b1;
        waddr_s      = top_idx_s;
      end
      OP_BYPASS: begin
        data_out_d   = data_in;
        data_valid_d = 1'b1;
      end
      default: begin
        data_valid_d = 1'b0;
      end
    endcase
    empty_d = (count_d == {CNT_W{1'b0}});
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= {CNT_W{1'b0}};
      data_out_q   <= {DATA_WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign top        = empty_q ? {DATA_WIDTH{1'b0}} : rd_top_s;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack at default size and at 16x5.
module tb_lifo_stack;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic       push0, pop0, clr0;
  logic [7:0] din0, dout0, top0;
  logic       dv0, empty0, full0, ovf0, unf0;
  logic [4:0] cnt0;

  logic        push1, pop1, clr1;
  logic [15:0] din1, dout1, top1;
  logic        dv1, empty1, full1, ovf1, unf1;
  logic [2:0]  cnt1;

  lifo_stack u_dut0 (
    .clk(clk), .reset(reset), .push(push0), .pop(pop0), .data_in(din0),
    .error_clr(clr0), .data_out(dout0), .data_valid(dv0), .top(top0),
    .count(cnt0), .empty(empty0), .full(full0), .overflow(ovf0), .underflow(unf0)
  );

  lifo_stack #(.DATA_WIDTH(16), .DEPTH(5)) u_dut1 (
    .clk(clk), .reset(reset), .push(push1), .pop(pop1), .data_in(din1),
    .error_clr(clr1), .data_out(dout1), .data_valid(dv1), .top(top1),
    .count(cnt1), .empty(empty1), .full(full1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle on the falling edge for checks/drive.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; din0 = 8'h00;
    push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; din1 = 16'h0000;
    @(negedge clk);
    step();
    reset = 1'b0;
    step(); step(); step();
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_dv", 32'(dv0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'h00);
    chk("rst_top", 32'(top0), 32'h00);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_unf", 32'(unf0), 32'd0);

    // LIFO ordering
    push0 = 1'b1; din0 = 8'h11; step();
    chk("push1_top", 32'(top0), 32'h11);
    chk("push1_cnt", 32'(cnt0), 32'd1);
    din0 = 8'h22; step();
    din0 = 8'h33; step();
    chk("push3_cnt", 32'(cnt0), 32'd3);
    chk("push3_dv", 32'(dv0), 32'd0);
    push0 = 1'b0; pop0 = 1'b1; step();
    chk("pop1_dout", 32'(dout0), 32'h33);
    chk("pop1_dv", 32'(dv0), 32'd1);
    chk("pop1_cnt", 32'(cnt0), 32'd2);
    step();
    chk("pop2_dout", 32'(dout0), 32'h22);
    chk("pop2_cnt", 32'(cnt0), 32'd1);
    step();
    chk("pop3_dout", 32'(dout0), 32'h11);
    chk("pop3_dv", 32'(dv0), 32'd1);
    chk("pop3_empty", 32'(empty0), 32'd1);
    pop0 = 1'b0; step();
    chk("idle_dv", 32'(dv0), 32'd0);
    chk("idle_dout_hold", 32'(dout0), 32'h11);

    // Fill to full, then overflow
    push0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din0 = 8'(i);
      step();
    end
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_cnt", 32'(cnt0), 32'd16);
    chk("fill_ovf", 32'(ovf0), 32'd0);
    din0 = 8'hAA; step();
    chk("ovf_flag", 32'(ovf0), 32'd1);
    chk("ovf_cnt", 32'(cnt0), 32'd16);
    chk("ovf_top", 32'(top0), 32'h0F);
    push0 = 1'b0; step();
    chk("ovf_sticky", 32'(ovf0), 32'd1);
    clr0 = 1'b1; step();
    chk("ovf_clr", 32'(ovf0), 32'd0);
    clr0 = 1'b0;
    push0 = 1'b1; pop0 = 1'b1; din0 = 8'hBB; step();
    chk("repl_dout", 32'(dout0), 32'h0F);
    chk("repl_dv", 32'(dv0), 32'd1);
    chk("repl_top", 32'(top0), 32'hBB);
    chk("repl_cnt", 32'(cnt0), 32'd16);
    chk("repl_ovf", 32'(ovf0), 32'd0);

    // Drain: replaced top first, then 0x0E down to 0x00
    push0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_dout", 32'(dout0), (i == 0) ? 32'hBB : 32'(15 - i));
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    pop0 = 1'b0;
    push0 = 1'b1; din0 = 8'h66; step();
    push0 = 1'b0; pop0 = 1'b1; step();
    chk("p66_dout", 32'(dout0), 32'h66);

    // Underflow
    step();
    chk("unf_flag", 32'(unf0), 32'd1);
    chk("unf_dv", 32'(dv0), 32'd0);
    chk("unf_dout_hold", 32'(dout0), 32'h66);
    chk("unf_cnt", 32'(cnt0), 32'd0);
    clr0 = 1'b1; step();
    chk("unf_set_wins", 32'(unf0), 32'd1);
    clr0 = 1'b0;
    push0 = 1'b1; din0 = 8'h5A; step();
    chk("byp_dout", 32'(dout0), 32'h5A);
    chk("byp_dv", 32'(dv0), 32'd1);
    chk("byp_cnt", 32'(cnt0), 32'd0);
    chk("byp_unf", 32'(unf0), 32'd1);
    chk("byp_top", 32'(top0), 32'h00);
    push0 = 1'b0; pop0 = 1'b0; step();
    chk("byp_dv_clear", 32'(dv0), 32'd0);

    // Reset overrides a pop in flight
    push0 = 1'b1; din0 = 8'h01; step();
    din0 = 8'h02; step();
    chk("pre_rst_cnt", 32'(cnt0), 32'd2);
    push0 = 1'b0; pop0 = 1'b1; reset = 1'b1; step();
    chk("rp_cnt", 32'(cnt0), 32'd0);
    chk("rp_dv", 32'(dv0), 32'd0);
    chk("rp_dout", 32'(dout0), 32'h00);
    chk("rp_unf", 32'(unf0), 32'd0);
    chk("rp_empty", 32'(empty0), 32'd1);
    reset = 1'b0; pop0 = 1'b0;
    push0 = 1'b1; din0 = 8'h77; step();
    push0 = 1'b0; pop0 = 1'b1; step();
    chk("post_rst_dout", 32'(dout0), 32'h77);
    chk("post_rst_dv", 32'(dv0), 32'd1);
    pop0 = 1'b0; step();

    // 16-bit x 5 instance
    push1 = 1'b1; din1 = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("p5_full", 32'(full1), 32'd1);
    chk("p5_cnt", 32'(cnt1), 32'd5);
    chk("p5_top", 32'(top1), 32'h1234);
    step();
    chk("p5_ovf", 32'(ovf1), 32'd1);
    chk("p5_ovf_cnt", 32'(cnt1), 32'd5);
    push1 = 1'b0; pop1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p5_dout", 32'(dout1), 32'h1234);
      chk("p5_dv", 32'(dv1), 32'd1);
    end
    chk("p5_empty", 32'(empty1), 32'd1);
    chk("p5_cnt0", 32'(cnt1), 32'd0);
    pop1 = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
